// File: rtl/queue_pkg.sv
// Shared types and sizing helpers for the handshake queue.
package queue_pkg;

  typedef enum logic {
    BACKPRESSURE     = 1'b0,
    OVERWRITE_OLDEST = 1'b1
  } full_policy_e;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries, never less than one.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/queue_ptr.sv
// Circular pointer that wraps at DEPTH-1 with explicit compare; clr beats inc.
module queue_ptr
  import queue_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/queue_hs.sv
// Single-clock valid/ready queue with arbitrary depth and backpressure or overwrite-oldest policy.
// Optional synchronous flush port is built when QUEUE_FLUSH_EN is defined.
module queue_hs
  import queue_pkg::*;
#(
  parameter int unsigned DATA      = 42,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 1,
  parameter int unsigned OVERWRITE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA-1:0]             in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA-1:0]             out_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
`ifdef QUEUE_FLUSH_EN
  input  logic                        flush,
`endif
  output logic                        overflow,
  input  logic                        ovf_clr
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned AW = addr_width(DEPTH);
  localparam full_policy_e POLICY = (OVERWRITE != 0) ? OVERWRITE_OLDEST : BACKPRESSURE;

  logic [DATA-1:0] mem_q [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            overflow_q;
  logic            overflow_d;
  logic [AW-1:0]   waddr;
  logic [AW-1:0]   raddr;
  logic            flush_c;
  logic            full_c;
  logic            empty_c;
  logic            in_ready_c;
  logic            push_c;
  logic            pop_c;
  logic            drop_c;

`ifdef QUEUE_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  // Full with a consumer taking the head still accepts a write in backpressure mode.
  always_comb begin
    in_ready_c = 1'b0;
    if (!rst && !flush_c) begin
      if (POLICY == OVERWRITE_OLDEST) begin
        in_ready_c = 1'b1;
      end else begin
        in_ready_c = !full_c || out_ready;
      end
    end
  end

  assign push_c = in_valid && in_ready_c;
  assign pop_c  = !empty_c && out_ready && !flush_c;
  // Only reachable in overwrite mode: the oldest entry is pushed out.
  assign drop_c = push_c && full_c && !pop_c;

  queue_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush_c),
    .inc (push_c),
    .ptr (waddr)
  );

  queue_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush_c),
    .inc (pop_c || drop_c),
    .ptr (raddr)
  );

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_c) begin
      count_d = '0;
    end else if (push_c && !pop_c && !full_c) begin
      count_d = count_q + CW'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CW'(1);
    end
    // A clear in the same cycle as a drop wins and the drop goes unrecorded.
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end else if (drop_c) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[waddr] <= in_data;
    end
  end

  assign in_ready     = in_ready_c;
  assign out_valid    = !empty_c;
  assign out_data     = mem_q[raddr];
  assign count        = count_q;
  assign full         = full_c;
  assign empty        = empty_c;
  assign almost_full  = (32'(count_q) >= AF_THRESH);
  assign almost_empty = (32'(count_q) <= AE_THRESH);
  assign overflow     = overflow_q;

  logic [31:0] ptr_gap_c;
  assign ptr_gap_c = (32'(waddr) + DEPTH - 32'(raddr)) % DEPTH;

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));

  a_ptr_bound: assert property (@(posedge clk) disable iff (rst)
    (32'(waddr) < DEPTH) && (32'(raddr) < DEPTH));

  a_count_ptr: assert property (@(posedge clk) disable iff (rst)
    (waddr == raddr) ? (empty_c || full_c) : (32'(count_q) == ptr_gap_c));

endmodule

// File: tb/tb_queue_hs.sv
// Scoreboard bench for queue_hs: one backpressure and one overwrite instance, DEPTH=5.
module tb_queue_hs;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 5;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_count;
  logic          b_full, b_empty, b_af, b_ae, b_ovf, b_ovf_clr;

  logic          o_in_valid, o_in_ready, o_out_valid, o_out_ready;
  logic [DW-1:0] o_in_data, o_out_data;
  logic [CW-1:0] o_count;
  logic          o_full, o_empty, o_af, o_ae, o_ovf, o_ovf_clr;

`ifdef QUEUE_FLUSH_EN
  logic b_flush, o_flush;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] b_exp[$];
  logic [DW-1:0] o_exp[$];

  queue_hs #(.DATA(DW), .DEPTH(DP), .OVERWRITE(0)) u_bp (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae),
`ifdef QUEUE_FLUSH_EN
    .flush(b_flush),
`endif
    .overflow(b_ovf), .ovf_clr(b_ovf_clr)
  );

  queue_hs #(.DATA(DW), .DEPTH(DP), .OVERWRITE(1)) u_ow (
    .clk(clk), .rst(rst),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data),
    .count(o_count), .full(o_full), .empty(o_empty),
    .almost_full(o_af), .almost_empty(o_ae),
`ifdef QUEUE_FLUSH_EN
    .flush(o_flush),
`endif
    .overflow(o_ovf), .ovf_clr(o_ovf_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output beat is compared against the head of its scoreboard.
  always @(negedge clk) begin
    if (b_out_valid && b_out_ready) begin
      if (b_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL bp_unexpected_pop actual=%0h required=none", b_out_data);
      end else begin
        chk("bp_pop_data", 32'(b_out_data), 32'(b_exp.pop_front()));
      end
    end
    if (o_out_valid && o_out_ready) begin
      if (o_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL ow_unexpected_pop actual=%0h required=none", o_out_data);
      end else begin
        chk("ow_pop_data", 32'(o_out_data), 32'(o_exp.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_ovf_clr = 1'b0;
    o_in_valid = 1'b0; o_in_data = '0; o_out_ready = 1'b0; o_ovf_clr = 1'b0;
`ifdef QUEUE_FLUSH_EN
    b_flush = 1'b0; o_flush = 1'b0;
`endif

    // Reset state, with producers asserting valid
    #2;
    b_in_valid = 1'b1; o_in_valid = 1'b1;
    #1;
    chk("rst_bp_in_ready", 32'(b_in_ready), 0);
    chk("rst_ow_in_ready", 32'(o_in_ready), 0);
    chk("rst_count", 32'(b_count), 0);
    chk("rst_empty", 32'(b_empty), 1);
    chk("rst_full", 32'(b_full), 0);
    chk("rst_out_valid", 32'(b_out_valid), 0);
    chk("rst_almost_empty", 32'(b_ae), 1);
    chk("rst_almost_full", 32'(b_af), 0);
    chk("rst_overflow", 32'(o_ovf), 0);
    b_in_valid = 1'b0; o_in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // Backpressure: fill A1..A5 with no consumer
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = DW'(32'hA1 + i);
      b_exp.push_back(DW'(32'hA1 + i));
      #1 chk("bp_fill_in_ready", 32'(b_in_ready), 1);
      tick();
      chk("bp_fill_count", 32'(b_count), 32'(i + 1));
      chk("bp_fill_almost_full", 32'(b_af), 32'(i + 1 >= 3));
      chk("bp_fill_full", 32'(b_full), 32'(i == 4));
    end
    b_in_data = 8'hFF;
    #1 chk("bp_full_in_ready", 32'(b_in_ready), 0);
    tick();
    chk("bp_full_reject_count", 32'(b_count), 5);

    // Full with simultaneous push and pop; write pointer already wrapped to 0
    b_out_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      b_in_data = DW'(32'hA6 + j);
      b_exp.push_back(DW'(32'hA6 + j));
      #1 chk("bp_full_pushpop_ready", 32'(b_in_ready), 1);
      tick();
      chk("bp_full_pushpop_count", 32'(b_count), 5);
      chk("bp_full_pushpop_full", 32'(b_full), 1);
    end
    b_in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 3) begin
        chk("bp_drain_count1", 32'(b_count), 1);
        chk("bp_drain_almost_empty", 32'(b_ae), 1);
      end
    end
    chk("bp_drained_empty", 32'(b_empty), 1);
    chk("bp_drained_out_valid", 32'(b_out_valid), 0);
    chk("bp_drained_count", 32'(b_count), 0);
    b_out_ready = 1'b0;

    // Push into empty queue: visible only the following cycle
    b_in_valid = 1'b1; b_in_data = 8'h2A;
    b_exp.push_back(8'h2A);
    #1 chk("bp_no_bypass", 32'(b_out_valid), 0);
    tick();
    b_in_valid = 1'b0;
    chk("bp_one_out_valid", 32'(b_out_valid), 1);
    chk("bp_one_out_data", 32'(b_out_data), 32'h2A);
    chk("bp_one_count", 32'(b_count), 1);
    chk("bp_one_almost_empty", 32'(b_ae), 1);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("bp_one_popped_empty", 32'(b_empty), 1);

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = DW'(32'h31 + i);
      tick();
    end
    b_in_data = 8'h34;
    chk("bp_pre_reset_count", 32'(b_count), 3);
    #2 rst = 1'b1;
    #1;
    chk("bp_async_rst_count", 32'(b_count), 0);
    chk("bp_async_rst_empty", 32'(b_empty), 1);
    chk("bp_async_rst_in_ready", 32'(b_in_ready), 0);
    b_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    b_in_valid = 1'b1; b_in_data = 8'h11;
    b_exp.push_back(8'h11);
    tick();
    b_in_valid = 1'b0;
    chk("bp_post_rst_count", 32'(b_count), 1);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;

    // Overwrite: 7 pushes into depth 5 drops 1 and 2
    for (int v = 3; v <= 7; v++) o_exp.push_back(DW'(v));
    for (int i = 0; i < 7; i++) begin
      o_in_valid = 1'b1;
      o_in_data  = DW'(i + 1);
      #1 chk("ow_in_ready", 32'(o_in_ready), 1);
      tick();
      if (i == 4) begin
        chk("ow_full_no_ovf", 32'(o_ovf), 0);
        chk("ow_full", 32'(o_full), 1);
      end
      if (i == 5) chk("ow_first_drop_ovf", 32'(o_ovf), 1);
    end
    o_in_valid = 1'b0;
    chk("ow_count", 32'(o_count), 5);
    chk("ow_overflow", 32'(o_ovf), 1);
    o_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    o_out_ready = 1'b0;
    chk("ow_drained_empty", 32'(o_empty), 1);
    chk("ow_ovf_sticky", 32'(o_ovf), 1);
    o_ovf_clr = 1'b1;
    tick();
    o_ovf_clr = 1'b0;
    chk("ow_ovf_cleared", 32'(o_ovf), 0);

    // Clear wins over a drop in the same cycle
    for (int i = 0; i < 5; i++) begin
      o_in_valid = 1'b1;
      o_in_data  = DW'(32'h81 + i);
      tick();
    end
    for (int v = 0; v < 5; v++) o_exp.push_back(DW'(32'h82 + v));
    o_in_data = 8'h86; o_ovf_clr = 1'b1;
    tick();
    o_in_valid = 1'b0; o_ovf_clr = 1'b0;
    chk("ow_clr_priority_ovf", 32'(o_ovf), 0);
    chk("ow_clr_priority_count", 32'(o_count), 5);
    o_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    o_out_ready = 1'b0;
    chk("ow_second_drain_empty", 32'(o_empty), 1);

`ifdef QUEUE_FLUSH_EN
    // Flush beats a simultaneous push
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = DW'(32'h41 + i);
      tick();
    end
    chk("fl_pre_count", 32'(b_count), 4);
    b_flush = 1'b1; b_in_data = 8'h99;
    #1 chk("fl_in_ready", 32'(b_in_ready), 0);
    tick();
    b_flush = 1'b0; b_in_valid = 1'b0;
    chk("fl_count", 32'(b_count), 0);
    chk("fl_empty", 32'(b_empty), 1);
    b_in_valid = 1'b1; b_in_data = 8'h55;
    b_exp.push_back(8'h55);
    tick();
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("fl_after_empty", 32'(b_empty), 1);
`endif

    chk("bp_never_overflows", 32'(b_ovf), 0);
    tick(); tick();
    chk("bp_scoreboard_drained", 32'(b_exp.size()), 0);
    chk("ow_scoreboard_drained", 32'(o_exp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
